// File: rtl/fp16_pkg.sv
// Shared types and constants for the binary16 multiplier: FSM states,
// IEEE half-precision constants and the unpacked-operand record.
package fp16_pkg;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] POS_INF  = 16'h7C00;
  localparam logic [15:0] QNAN     = 16'h7E00;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MUL,
    NORM,
    DONE
  } state_t;

  // mant carries the hidden bit; a zero or subnormal operand has is_zero set
  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [10:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp16_unpacked_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational field split and classification of one binary16 operand.
// Subnormals are classified as zero so the multiplier flushes them.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]    x,
  output fp16_unpacked_t u
);

  logic exp_all_ones;
  logic exp_all_zero;

  assign exp_all_ones = (x[14:10] == 5'h1F);
  assign exp_all_zero = (x[14:10] == 5'h00);

  always_comb begin
    u.sign    = x[15];
    u.exp     = x[14:10];
    u.mant    = {~exp_all_zero, x[9:0]};
    u.is_zero = exp_all_zero;
    u.is_inf  = exp_all_ones && (x[9:0] == 10'd0);
    u.is_nan  = exp_all_ones && (x[9:0] != 10'd0);
  end

endmodule

// File: rtl/fp16_mul_seq.sv
// Multi-cycle binary16 multiplier with an LSB-first shift-add mantissa datapath.
// Define FP16_RNE_EN to round to nearest-even in NORM; otherwise results truncate.
module fp16_mul_seq #(
  parameter int          MANT_W = 11,
  parameter logic [15:0] QNAN   = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  import fp16_pkg::*;

  localparam int PW    = 2 * MANT_W;
  localparam int FW    = MANT_W - 1;
  localparam int CNT_W = $clog2(MANT_W + 1);

  state_t             state;
  logic [15:0]        a_q;
  logic [15:0]        b_q;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic signed [6:0]  e_q;
  logic               sign_q;
  logic               special_q;

  fp16_unpacked_t     ua;
  fp16_unpacked_t     ub;

  logic               sp_hit;
  logic [15:0]        sp_res;
  logic [2:0]         sp_flags;

  logic [MANT_W:0]    add_sum;

  logic [FW-1:0]      frac;
  logic [FW-1:0]      frac_out;
  logic signed [6:0]  e_norm;
  logic signed [6:0]  e_out;
  logic [15:0]        norm_res;
  logic [2:0]         norm_flags;

`ifdef FP16_RNE_EN
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [FW:0]        frac_rnd;
`endif

  fp16_unpack u_unpack_a (
    .x (a_q),
    .u (ua)
  );

  fp16_unpack u_unpack_b (
    .x (b_q),
    .u (ub)
  );

  // NaN wins over everything, then inf*zero, then the remaining inf and zero cases
  always_comb begin
    sp_hit   = 1'b1;
    sp_res   = 16'h0000;
    sp_flags = 3'b000;
    if (ua.is_nan || ub.is_nan) begin
      sp_res = QNAN;
    end else if ((ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
      sp_res   = QNAN;
      sp_flags = 3'b100;
    end else if (ua.is_inf || ub.is_inf) begin
      sp_res = {ua.sign ^ ub.sign, POS_INF[14:0]};
    end else if (ua.is_zero || ub.is_zero) begin
      sp_res = {ua.sign ^ ub.sign, 15'h0000};
    end else begin
      sp_hit = 1'b0;
    end
  end

  assign add_sum = {1'b0, acc[PW-1:MANT_W]} + (acc[0] ? {1'b0, ua.mant} : '0);

  // Both operands are normal here, so the product MSB is bit PW-1 or PW-2
  always_comb begin
    if (acc[PW-1]) begin
      frac   = acc[PW-2 -: FW];
      e_norm = e_q + 7'sd1;
    end else begin
      frac   = acc[PW-3 -: FW];
      e_norm = e_q;
    end

`ifdef FP16_RNE_EN
    guard    = acc[PW-1] ? acc[MANT_W-1] : acc[MANT_W-2];
    sticky   = acc[PW-1] ? (|acc[MANT_W-2:0]) : (|acc[MANT_W-3:0]);
    round_up = guard && (sticky || frac[0]);
    frac_rnd = {1'b0, frac} + {{FW{1'b0}}, round_up};
    frac_out = frac_rnd[FW-1:0];
    e_out    = e_norm + $signed({6'b000000, frac_rnd[FW]});
`else
    frac_out = frac;
    e_out    = e_norm;
`endif

    norm_res   = {sign_q, e_out[4:0], frac_out};
    norm_flags = 3'b000;
    if (e_out >= $signed(7'(EXP_MAX))) begin
      norm_res   = {sign_q, POS_INF[14:0]};
      norm_flags = 3'b010;
    end else if (e_out <= 7'sd0) begin
      norm_res   = {sign_q, 15'h0000};
      norm_flags = 3'b001;
    end
  end

  // Specials still pass through NORM so every result leaves via the same path
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 16'h0000;
      flags     <= 3'b000;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      acc       <= '0;
      cnt       <= '0;
      e_q       <= 7'sd0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end

        UNPACK: begin
          sign_q    <= ua.sign ^ ub.sign;
          e_q       <= $signed({2'b00, ua.exp} + {2'b00, ub.exp} - 7'(EXP_BIAS));
          acc       <= {{MANT_W{1'b0}}, ub.mant};
          cnt       <= '0;
          special_q <= sp_hit;
          if (sp_hit) begin
            result <= sp_res;
            flags  <= sp_flags;
            state  <= NORM;
          end else begin
            state  <= MUL;
          end
        end

        MUL: begin
          acc <= {add_sum, acc[MANT_W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MANT_W - 1)) begin
            state <= NORM;
          end
        end

        NORM: begin
          if (!special_q) begin
            result <= norm_res;
            flags  <= norm_flags;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Self-checking bench for fp16_mul_seq: directed vectors plus random operands
// against a value-level binary16 reference model.
module tb_fp16_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  fp16_mul_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact integer product of the significands, normalized into [1024,2048)
  function automatic void refModel(input logic [15:0] x, input logic [15:0] y,
                                   output logic [15:0] r, output logic [2:0] f,
                                   output bit special);
    int     ex, ey, e, sh;
    logic   s;
    bit     xnan, ynan, xinf, yinf, xz, yz;
    longint mx, my, p, m;
`ifdef FP16_RNE_EN
    longint rem, half;
`endif
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    s  = x[15] ^ y[15];
    xnan = (ex == 31) && (x[9:0] != 0);
    ynan = (ey == 31) && (y[9:0] != 0);
    xinf = (ex == 31) && (x[9:0] == 0);
    yinf = (ey == 31) && (y[9:0] == 0);
    xz   = (ex == 0);
    yz   = (ey == 0);
    special = 1'b1;
    f = 3'b000;
    r = 16'h0000;
    if (xnan || ynan) begin
      r = 16'h7E00;
    end else if ((xinf && yz) || (xz && yinf)) begin
      r = 16'h7E00;
      f = 3'b100;
    end else if (xinf || yinf) begin
      r = {s, 15'h7C00};
    end else if (xz || yz) begin
      r = {s, 15'h0000};
    end else begin
      special = 1'b0;
      mx = 1024 + longint'(x[9:0]);
      my = 1024 + longint'(y[9:0]);
      p  = mx * my;
      m  = p;
      sh = 0;
      while (m >= 2048) begin
        m = m >> 1;
        sh++;
      end
      e = ex + ey - 25 + sh;
`ifdef FP16_RNE_EN
      rem  = p - (m << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && m[0])) begin
        m++;
        if (m == 2048) begin
          m = 1024;
          e++;
        end
      end
`endif
      if (e >= 31) begin
        r = {s, 15'h7C00};
        f = 3'b010;
      end else if (e <= 0) begin
        r = {s, 15'h0000};
        f = 3'b001;
      end else begin
        r = {s, 5'(e), 10'(m - 1024)};
      end
    end
  endfunction

  // Waits for done from the cycle after the accepting edge; returns that cycle count
  task automatic waitDone(input string tag, output int cyc);
    int busyLow;
    busyLow = 0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) busyLow++;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_busy_gap"}, 32'(busyLow), 32'd0);
    checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] ta, input logic [15:0] tb);
    logic [15:0] expRes;
    logic [2:0]  expFlg;
    bit          special;
    int          cyc;
    refModel(ta, tb, expRes, expFlg, special);
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    waitDone(tag, cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), special ? 32'd3 : 32'd14);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_flags"}, 32'(flags), 32'(expFlg));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic logic [15:0] randOperand();
    logic [4:0] e;
    case ($urandom_range(0, 9))
      0:       e = 5'd0;
      1:       e = 5'd31;
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  initial begin
    logic [15:0] r1, r2, a1, b1, a2, b2;
    logic [2:0]  f1, f2;
    bit          sp1, sp2;
    int          cyc, doneSeen;

    reset = 1'b0;
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    reset = 1'b1;

    applyStimulus("one_x_m2", 16'h3C00, 16'hC000);
    applyStimulus("1p5_sq", 16'h3E00, 16'h3E00);
    applyStimulus("round_case", 16'h3E01, 16'h3E01);
    applyStimulus("overflow", 16'h7BFF, 16'h4000);
    applyStimulus("underflow", 16'h0400, 16'h0400);
    applyStimulus("inf_x_zero", 16'h7C00, 16'h0000);
    applyStimulus("nan_in", 16'h7E00, 16'h3C00);
    applyStimulus("neg_inf", 16'hFC00, 16'h4000);
    applyStimulus("subnorm_zero", 16'h0001, 16'hC000);
    applyStimulus("max_sq_lo", 16'h3BFF, 16'h3BFF);

    for (int i = 0; i < 30; i++) begin
      applyStimulus($sformatf("rand%0d", i), randOperand(), randOperand());
    end

    // start held high with operands changing every cycle
    a1 = 16'h4248;
    b1 = 16'hBD55;
    a2 = 16'h3A9C;
    b2 = 16'h4F11;
    refModel(a1, b1, r1, f1, sp1);
    refModel(a2, b2, r2, f2, sp2);
    @(negedge clk);
    start = 1'b1;
    a = a1;
    b = b1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 40) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    checkOutput("held_first_latency", 32'(cyc), 32'd14);
    checkOutput("held_first_result", 32'(result), 32'(r1));
    a = 16'h7E00;
    b = 16'h7C00;
    @(negedge clk);
    a = a2;
    b = b2;
    @(negedge clk);
    a = 16'h7C00;
    b = 16'h0000;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("held_second_latency", 32'(cyc), sp2 ? 32'd3 : 32'd14);
    checkOutput("held_second_result", 32'(result), 32'(r2));
    checkOutput("held_second_flags", 32'(flags), 32'(f2));

    // reset asserted while the multiply loop is running
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 16'h3C00;
    b = 16'h4000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_result", 32'(result), 32'd0);
    checkOutput("mid_reset_flags", 32'(flags), 32'd0);
    doneSeen = 0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("mid_reset_no_done", 32'(doneSeen), 32'd0);

    applyStimulus("after_reset", 16'h3E00, 16'h3E00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
